ysyx_22040632_axi_sram: RTL and testbench
=========================================

Name: ysyx_22040632_axi_sram

Overview:
- AXI4 slave memory model. Consumes the AXI4 master bus driven by the core top and backs it with an internal 64-bit-wide SRAM array.
- Serves instruction fetches and data accesses that the core's arbiter forwards.
- Supports FIXED and INCR bursts up to 256 beats, narrow transfers and write strobes. Reads and writes are serialized through one FSM with alternating priority.
- Sits directly downstream of the core top in the simulation SoC.

Parameters:
- AXI_DATA_WIDTH, 64, data bus width; only 64 is supported.
- AXI_ADDR_WIDTH, 32, address width.
- AXI_ID_WIDTH, 4, transaction ID width.
- MEM_WORDS, 4096, number of 64-bit words in the array (32 KiB).
- BASE_ADDR, 32'h8000_0000, byte address of word 0.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- aw_valid/aw_ready  in/out  1  write-address handshake.
- aw_addr  in  32  write start byte address.
- aw_id  in  4  write ID.
- aw_len  in  8  beats minus 1.
- aw_size  in  3  log2 bytes per beat.
- aw_burst  in  2  burst type.
- w_valid/w_ready  in/out  1  write-data handshake.
- w_data  in  64  write data.
- w_strb  in  8  byte-lane enables.
- w_last  in  1  final write beat.
- b_valid/b_ready  out/in  1  write-response handshake.
- b_resp  out  2  write response.
- b_id  out  4  echoes aw_id.
- ar_valid/ar_ready  in/out  1  read-address handshake.
- ar_addr  in  32  read start byte address.
- ar_id  in  4  read ID.
- ar_len  in  8  beats minus 1.
- ar_size  in  3  log2 bytes per beat.
- ar_burst  in  2  burst type.
- r_valid/r_ready  out/in  1  read-data handshake.
- r_data  out  64  read data.
- r_resp  out  2  read response.
- r_last  out  1  final read beat.
- r_id  out  4  echoes ar_id.

Behaviour:
- Reset (rst_n low, async):
  - All outputs go to 0: ready, valid, resp, last, id and data.
  - FSM goes to IDLE; beat counters, latched request fields and error flags clear; priority flag resets to read-first.
  - The SRAM array is never reset. Contents survive reset, including a reset asserted mid-burst.
  - Any in-flight transaction is abandoned with no response.
- States: IDLE, RDATA, WDATA, WRESP.
- IDLE:
  - ar_ready and aw_ready are driven high combinationally only in IDLE, only for the channel being granted.
  - If both ar_valid and aw_valid are high, grant the channel opposite to the last one granted (read first after reset). Otherwise grant whichever is valid.
  - On handshake, latch addr/id/len/size/burst. Clear the beat counter. Go to RDATA or WDATA.
- Address generation:
  - beat_addr starts at the request address.
  - INCR: after each beat, add (1 << size), 32-bit wrap.
  - FIXED: beat_addr is held.
  - Word index = (beat_addr - BASE_ADDR) >> 3.
  - In range means BASE_ADDR <= beat_addr < BASE_ADDR + MEM_WORDS*8.
- Error conditions:
  - size > 3 or burst == 2'b10 (WRAP) or 2'b11 sets a latched SLVERR (2'b10) for the whole transaction.
  - Any beat out of range gives DECERR (2'b11). DECERR overrides SLVERR.
- RDATA:
  - r_valid is asserted the cycle after the AR handshake (1-cycle latency).
  - r_data is the full 64-bit word at the index. The master selects byte lanes. The value is 0 if out of range or errored.
  - r_id holds the latched ID. r_resp is the per-beat response (OKAY 2'b00 otherwise).
  - r_last is high when counter == len.
  - r_data/r_resp/r_last are held stable while r_valid && !r_ready.
  - Each r_valid && r_ready advances address and counter, and the next beat is presented the next cycle (one beat per cycle at full throughput).
  - The last beat's handshake returns to IDLE.
- WDATA:
  - w_ready is high.
  - On each w_valid && w_ready, write the lanes with w_strb set, only if in range and no SLVERR. Advance address and counter.
  - If w_last disagrees with (counter == len), set a sticky SLVERR.
  - Leave WDATA on the beat where counter == len, regardless of w_last.
- WRESP:
  - b_valid is high, with b_id latched and b_resp = worst of {OKAY, SLVERR, DECERR} over the burst.
  - Hold until b_ready, then return to IDLE.
- Simultaneous events:
  - A read of an address written in the same cycle is impossible (channels are serialized).
  - A write to the last word followed by an INCR beyond the end marks the remaining beats DECERR and does not wrap.
- len = 0 is a single beat: r_last asserts with the first beat, and WDATA exits after one beat.

Test Plan:
- Write 0x1122334455667788 to 0x80000000, strb 0xFF, len 0, then read 0x80000000 -> b_resp 0, r_data 0x1122334455667788, r_last 1, r_valid exactly 1 cycle after the AR handshake.
- Write strb 0x0F data 0xFFFFFFFFAAAAAAAA over that word, then read -> 0x11223344AAAAAAAA.
- INCR read len 3 at 0x80000010 with r_ready toggling 1,0,1,0 -> 4 beats, data stable during stalls, r_last only on beat 4, r_id echoed.
- ar_valid and aw_valid asserted together twice -> first grant read, second grant write. Write of len 1 with w_last on beat 0 -> b_resp 2'b10.
- Read 0x7FFFFFF8 and read 0x80008000 -> r_resp 2'b11, r_data 0. Write to the same addresses -> b_resp 2'b11, array unchanged.
- Assert rst_n low during beat 2 of an 8-beat write -> all outputs 0 immediately. After release, words from beats 0-1 are readable, ar_ready is high in IDLE, and no b response is issued.

Source files
------------

// File: rtl/ysyx_22040632_axi_sram.sv
// AXI4 slave backed by a 64-bit-wide on-chip SRAM; one FSM serialises reads and writes.
// Supports FIXED/INCR bursts, narrow beats, byte strobes, SLVERR/DECERR responses.
module ysyx_22040632_axi_sram #(
  parameter int                        AXI_DATA_WIDTH = 64,
  parameter int                        AXI_ADDR_WIDTH = 32,
  parameter int                        AXI_ID_WIDTH   = 4,
  parameter int                        MEM_WORDS      = 4096,
  parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR      = 32'h8000_0000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        aw_valid,
  output logic                        aw_ready,
  input  logic [AXI_ADDR_WIDTH-1:0]   aw_addr,
  input  logic [AXI_ID_WIDTH-1:0]     aw_id,
  input  logic [7:0]                  aw_len,
  input  logic [2:0]                  aw_size,
  input  logic [1:0]                  aw_burst,
  input  logic                        w_valid,
  output logic                        w_ready,
  input  logic [AXI_DATA_WIDTH-1:0]   w_data,
  input  logic [AXI_DATA_WIDTH/8-1:0] w_strb,
  input  logic                        w_last,
  output logic                        b_valid,
  input  logic                        b_ready,
  output logic [1:0]                  b_resp,
  output logic [AXI_ID_WIDTH-1:0]     b_id,
  input  logic                        ar_valid,
  output logic                        ar_ready,
  input  logic [AXI_ADDR_WIDTH-1:0]   ar_addr,
  input  logic [AXI_ID_WIDTH-1:0]     ar_id,
  input  logic [7:0]                  ar_len,
  input  logic [2:0]                  ar_size,
  input  logic [1:0]                  ar_burst,
  output logic                        r_valid,
  input  logic                        r_ready,
  output logic [AXI_DATA_WIDTH-1:0]   r_data,
  output logic [1:0]                  r_resp,
  output logic                        r_last,
  output logic [AXI_ID_WIDTH-1:0]     r_id
);
  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam logic [AXI_ADDR_WIDTH-1:0] MEM_BYTES = AXI_ADDR_WIDTH'(MEM_WORDS * 8);

  typedef enum logic [1:0] {IDLE, RDATA, WDATA, WRESP} state_e;

  state_e                    state_q;
  logic [AXI_ADDR_WIDTH-1:0] addr_q;
  logic [AXI_ID_WIDTH-1:0]   id_q;
  logic [7:0]                len_q, cnt_q;
  logic [2:0]                size_q;
  logic [1:0]                burst_q;
  logic                      slverr_q, decerr_q, prio_rd_q;
  logic                      r_last_q, r_zero_q;
  logic [1:0]                r_resp_q, b_resp_q;

  function automatic logic in_range(input logic [AXI_ADDR_WIDTH-1:0] a);
    return (a - BASE_ADDR) < MEM_BYTES;
  endfunction

  function automatic logic cfg_err(input logic [2:0] size, input logic [1:0] burst);
    return (size > 3'd3) || burst[1];
  endfunction

  function automatic logic [1:0] beat_resp(input logic oor, input logic slv);
    return oor ? 2'b11 : (slv ? 2'b10 : 2'b00);
  endfunction

  logic                      idle, grant_rd, ar_hs, aw_hs, r_hs, w_hs;
  logic [AXI_ADDR_WIDTH-1:0] next_addr, rd_addr, rd_off, wr_off;
  logic [IDX_W-1:0]          rd_idx, wr_idx;
  logic                      rd_en, wr_en, rd_oor, rd_cfg, wr_oor, wr_mism, wr_final;
  logic [AXI_DATA_WIDTH-1:0] mem_rdata;

  assign idle     = (state_q == IDLE);
  assign grant_rd = ar_valid && (!aw_valid || prio_rd_q);
  assign ar_ready = rst_n && idle && grant_rd;
  assign aw_ready = rst_n && idle && aw_valid && !grant_rd;
  assign ar_hs    = ar_valid && ar_ready;
  assign aw_hs    = aw_valid && aw_ready;
  assign r_hs     = r_valid && r_ready;
  assign w_hs     = w_valid && w_ready;

  // FIXED holds the address; everything else steps by the beat size with natural 32-bit wrap.
  assign next_addr = (burst_q == 2'b00) ? addr_q : addr_q + (AXI_ADDR_WIDTH'(1) << size_q);

  // The read port looks one beat ahead so the next word is ready right after each handshake.
  assign rd_addr = idle ? ar_addr : next_addr;
  assign rd_off  = rd_addr - BASE_ADDR;
  assign rd_idx  = IDX_W'(rd_off >> 3);
  assign rd_en   = ar_hs || (r_hs && !r_last_q);
  assign rd_oor  = !in_range(rd_addr);
  assign rd_cfg  = idle ? cfg_err(ar_size, ar_burst) : slverr_q;

  assign wr_off   = addr_q - BASE_ADDR;
  assign wr_idx   = IDX_W'(wr_off >> 3);
  assign wr_oor   = !in_range(addr_q);
  assign wr_en    = (state_q == WDATA) && w_hs && !wr_oor && !slverr_q;
  assign wr_final = (cnt_q == len_q);
  assign wr_mism  = (w_last != wr_final);

  generate
    for (genvar gi = 0; gi < AXI_DATA_WIDTH / 8; gi++) begin : g_lane
      logic [7:0] mem [MEM_WORDS];
      logic [7:0] rdata_q;
      always_ff @(posedge clk) begin
        if (wr_en && w_strb[gi]) mem[wr_idx] <= w_data[gi*8 +: 8];
        if (rd_en) rdata_q <= mem[rd_idx];
      end
      assign mem_rdata[gi*8 +: 8] = rdata_q;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      id_q      <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      slverr_q  <= 1'b0;
      decerr_q  <= 1'b0;
      prio_rd_q <= 1'b1;
      r_last_q  <= 1'b0;
      r_zero_q  <= 1'b0;
      r_resp_q  <= 2'b00;
      b_resp_q  <= 2'b00;
    end else begin
      case (state_q)
        IDLE: begin
          if (ar_hs) begin
            addr_q    <= ar_addr;
            id_q      <= ar_id;
            len_q     <= ar_len;
            size_q    <= ar_size;
            burst_q   <= ar_burst;
            cnt_q     <= '0;
            slverr_q  <= rd_cfg;
            decerr_q  <= 1'b0;
            prio_rd_q <= 1'b0;
            r_last_q  <= (ar_len == 8'd0);
            r_resp_q  <= beat_resp(rd_oor, rd_cfg);
            r_zero_q  <= rd_oor || rd_cfg;
            state_q   <= RDATA;
          end else if (aw_hs) begin
            addr_q    <= aw_addr;
            id_q      <= aw_id;
            len_q     <= aw_len;
            size_q    <= aw_size;
            burst_q   <= aw_burst;
            cnt_q     <= '0;
            slverr_q  <= cfg_err(aw_size, aw_burst);
            decerr_q  <= 1'b0;
            prio_rd_q <= 1'b1;
            state_q   <= WDATA;
          end
        end
        RDATA: begin
          if (r_hs) begin
            if (r_last_q) begin
              r_last_q <= 1'b0;
              r_resp_q <= 2'b00;
              state_q  <= IDLE;
            end else begin
              addr_q   <= next_addr;
              cnt_q    <= cnt_q + 8'd1;
              r_last_q <= ((cnt_q + 8'd1) == len_q);
              r_resp_q <= beat_resp(rd_oor, rd_cfg);
              r_zero_q <= rd_oor || rd_cfg;
            end
          end
        end
        WDATA: begin
          if (w_hs) begin
            addr_q   <= next_addr;
            cnt_q    <= cnt_q + 8'd1;
            decerr_q <= decerr_q || wr_oor;
            slverr_q <= slverr_q || wr_mism;
            // The burst ends on the counted last beat even if w_last disagrees.
            if (wr_final) begin
              b_resp_q <= beat_resp(decerr_q || wr_oor, slverr_q || wr_mism);
              state_q  <= WRESP;
            end
          end
        end
        WRESP: begin
          if (b_ready) begin
            b_resp_q <= 2'b00;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign r_valid = (state_q == RDATA);
  assign r_data  = (r_valid && !r_zero_q) ? mem_rdata : '0;
  assign r_resp  = r_resp_q;
  assign r_last  = r_last_q;
  assign r_id    = id_q;
  assign w_ready = (state_q == WDATA);
  assign b_valid = (state_q == WRESP);
  assign b_resp  = b_resp_q;
  assign b_id    = id_q;

endmodule

// File: tb/tb_ysyx_22040632_axi_sram.sv
// Scoreboard bench for the AXI SRAM slave: expected beats and responses are queued
// when requests are issued and compared by a monitor as the slave produces them.
module tb_ysyx_22040632_axi_sram;
  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam logic [31:0] LIMIT = 32'h8000_8000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        aw_valid = 0, aw_ready;
  logic [31:0] aw_addr = '0;
  logic [3:0]  aw_id = '0;
  logic [7:0]  aw_len = '0;
  logic [2:0]  aw_size = '0;
  logic [1:0]  aw_burst = '0;
  logic        w_valid = 0, w_ready;
  logic [63:0] w_data = '0;
  logic [7:0]  w_strb = '0;
  logic        w_last = 0;
  logic        b_valid, b_ready = 0;
  logic [1:0]  b_resp;
  logic [3:0]  b_id;
  logic        ar_valid = 0, ar_ready;
  logic [31:0] ar_addr = '0;
  logic [3:0]  ar_id = '0;
  logic [7:0]  ar_len = '0;
  logic [2:0]  ar_size = '0;
  logic [1:0]  ar_burst = '0;
  logic        r_valid, r_ready = 0;
  logic [63:0] r_data;
  logic [1:0]  r_resp;
  logic        r_last;
  logic [3:0]  r_id;

  always #5 clk = ~clk;

  ysyx_22040632_axi_sram dut (
    .clk(clk), .rst_n(rst_n),
    .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr), .aw_id(aw_id),
    .aw_len(aw_len), .aw_size(aw_size), .aw_burst(aw_burst),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_strb(w_strb), .w_last(w_last),
    .b_valid(b_valid), .b_ready(b_ready), .b_resp(b_resp), .b_id(b_id),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr), .ar_id(ar_id),
    .ar_len(ar_len), .ar_size(ar_size), .ar_burst(ar_burst),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_resp(r_resp),
    .r_last(r_last), .r_id(r_id)
  );

  typedef struct packed {
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [3:0]  id;
  } r_exp_t;

  typedef struct packed {
    logic [1:0] resp;
    logic [3:0] id;
  } b_exp_t;

  r_exp_t      exp_r[$];
  b_exp_t      exp_b[$];
  logic [63:0] model [int];
  int          n_chk = 0;
  int          n_pass = 0;
  r_exp_t      mon_r;
  b_exp_t      mon_b;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
  endtask

  function automatic bit in_rng(input logic [31:0] a);
    return (a >= BASE) && (a < LIMIT);
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a - BASE) >> 3);
  endfunction

  function automatic logic [31:0] step(input logic [31:0] a, input logic [2:0] size, input logic [1:0] burst);
    return (burst == 2'b00) ? a : a + (32'd1 << size);
  endfunction

  // Monitor: every visible read beat is compared against the queue head, so stalled beats
  // are re-checked each cycle; the entry is retired only on the handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (b_valid && b_ready) begin
        if (exp_b.size() == 0) check_eq("b_unexpected", 64'd1, 64'd0);
        else begin
          mon_b = exp_b.pop_front();
          check_eq("b_resp", 64'(b_resp), 64'(mon_b.resp));
          check_eq("b_id", 64'(b_id), 64'(mon_b.id));
          $display("B  id=%0h resp=%0d", b_id, b_resp);
        end
      end
      if (r_valid) begin
        if (exp_r.size() == 0) check_eq("r_unexpected", 64'd1, 64'd0);
        else begin
          mon_r = exp_r[0];
          check_eq("r_data", r_data, mon_r.data);
          check_eq("r_resp", 64'(r_resp), 64'(mon_r.resp));
          check_eq("r_last", 64'(r_last), 64'(mon_r.last));
          check_eq("r_id", 64'(r_id), 64'(mon_r.id));
          if (r_ready) begin
            void'(exp_r.pop_front());
            $display("R  id=%0h data=%h resp=%0d last=%0d", r_id, r_data, r_resp, r_last);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_r_exp(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input bit cfg_bad);
    logic [31:0] a;
    r_exp_t e;
    a = addr;
    for (int i = 0; i <= int'(len); i++) begin
      e.id   = id;
      e.last = (i == int'(len));
      if (!in_rng(a)) begin
        e.resp = 2'b11;
        e.data = '0;
      end else if (cfg_bad) begin
        e.resp = 2'b10;
        e.data = '0;
      end else begin
        e.resp = 2'b00;
        e.data = model.exists(widx(a)) ? model[widx(a)] : 64'd0;
      end
      exp_r.push_back(e);
      a = step(a, size, burst);
    end
  endtask

  task automatic send_aw(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int n;
    aw_addr = addr; aw_id = id; aw_len = len; aw_size = size; aw_burst = burst;
    aw_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (aw_ready) break;
      n++;
      if (n > 50) begin check_eq("aw_timeout", 64'd1, 64'd0); break; end
    end
    tick();
    aw_valid = 1'b0;
  endtask

  task automatic send_w(input logic [63:0] data, input logic [7:0] strb, input logic last);
    int n;
    w_data = data; w_strb = strb; w_last = last; w_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (w_ready) break;
      n++;
      if (n > 50) begin check_eq("w_timeout", 64'd1, 64'd0); break; end
    end
    tick();
    w_valid = 1'b0;
  endtask

  task automatic wait_b();
    int n;
    n = 0;
    while (exp_b.size() != 0 && n < 50) begin tick(); n++; end
    if (exp_b.size() != 0) begin
      check_eq("b_timeout", 64'd1, 64'd0);
      exp_b.delete();
    end
  endtask

  task automatic drain_r(input logic [3:0] pat);
    int cyc;
    cyc = 0;
    while (exp_r.size() != 0) begin
      tick();
      cyc++;
      if (cyc > 200) begin
        check_eq("r_timeout", 64'd1, 64'd0);
        exp_r.delete();
        break;
      end
      r_ready = pat[cyc % 4];
    end
    r_ready = 1'b0;
  endtask

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] data, input logic [7:0] strb);
    logic [63:0] m;
    m = old;
    for (int b = 0; b < 8; b++) if (strb[b]) m[b*8 +: 8] = data[b*8 +: 8];
    return m;
  endfunction

  task automatic write_burst(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst, input logic [63:0] data,
                             input logic [7:0] strb, input logic [1:0] exp_resp);
    logic [31:0] a;
    b_exp_t e;
    e.resp = exp_resp; e.id = id;
    exp_b.push_back(e);
    send_aw(addr, id, len, size, burst);
    a = addr;
    for (int i = 0; i <= int'(len); i++) begin
      send_w(data + 64'(i), strb, i == int'(len));
      if (in_rng(a))
        model[widx(a)] = merge(model.exists(widx(a)) ? model[widx(a)] : 64'd0, data + 64'(i), strb);
      a = step(a, size, burst);
    end
    wait_b();
  endtask

  task automatic read_burst(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input logic [3:0] pat,
                            input bit cfg_bad);
    int n;
    push_r_exp(addr, id, len, size, burst, cfg_bad);
    ar_addr = addr; ar_id = id; ar_len = len; ar_size = size; ar_burst = burst;
    ar_valid = 1'b1;
    @(negedge clk);
    check_eq("ar_ready_idle", 64'(ar_ready), 64'd1);
    n = 0;
    while (!ar_ready && n < 50) begin @(negedge clk); n++; end
    tick();
    ar_valid = 1'b0;
    r_ready = pat[0];
    @(negedge clk);
    check_eq("r_latency", 64'(r_valid), 64'd1);
    drain_r(pat);
  endtask

  initial begin
    b_ready = 1'b1;
    ar_valid = 1'b1;
    aw_valid = 1'b1;
    #12;
    check_eq("rst_ar_ready", 64'(ar_ready), 64'd0);
    check_eq("rst_aw_ready", 64'(aw_ready), 64'd0);
    check_eq("rst_outs", {58'd0, w_ready, b_valid, r_valid, r_last, b_resp == 2'b00, r_resp == 2'b00}, 64'd3);
    check_eq("rst_r_data", r_data, 64'd0);
    ar_valid = 1'b0;
    aw_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // Full-word write/read, then strobed partial overwrite.
    write_burst(BASE, 4'h1, 8'd0, 3'd3, 2'b01, 64'h1122334455667788, 8'hFF, 2'b00);
    read_burst(BASE, 4'h2, 8'd0, 3'd3, 2'b01, 4'b1111, 1'b0);
    write_burst(BASE, 4'h1, 8'd0, 3'd3, 2'b01, 64'hFFFFFFFFAAAAAAAA, 8'h0F, 2'b00);
    read_burst(BASE, 4'h3, 8'd0, 3'd3, 2'b01, 4'b1111, 1'b0);

    // INCR burst, read back with r_ready toggling 1,0,1,0.
    write_burst(BASE + 32'h10, 4'h4, 8'd3, 3'd3, 2'b01, 64'hA0A0_0000_0000_1000, 8'hFF, 2'b00);
    read_burst(BASE + 32'h10, 4'h5, 8'd3, 3'd3, 2'b01, 4'b0101, 1'b0);

    // FIXED burst: both beats land on one word; narrow INCR read stays within one word.
    write_burst(BASE + 32'h20, 4'h6, 8'd1, 3'd3, 2'b00, 64'h5555_6666_7777_8880, 8'hFF, 2'b00);
    read_burst(BASE + 32'h20, 4'h6, 8'd1, 3'd3, 2'b00, 4'b1111, 1'b0);
    read_burst(BASE + 32'h10, 4'h7, 8'd1, 3'd2, 2'b01, 4'b1111, 1'b0);

    // Last word then one beat past the end: second beat is DECERR, no wrap to word 0.
    write_burst(LIMIT - 32'h8, 4'h8, 8'd1, 3'd3, 2'b01, 64'hDEAD_BEEF_0000_0000, 8'hFF, 2'b11);

    // Simultaneous AR/AW after a write grant: read wins, then write wins.
    push_r_exp(BASE, 4'h9, 8'd0, 3'd3, 2'b01, 1'b0);
    ar_addr = BASE; ar_id = 4'h9; ar_len = 8'd0; ar_size = 3'd3; ar_burst = 2'b01;
    aw_addr = BASE + 32'h200; aw_id = 4'hA; aw_len = 8'd1; aw_size = 3'd3; aw_burst = 2'b01;
    ar_valid = 1'b1;
    aw_valid = 1'b1;
    @(negedge clk);
    check_eq("prio1_ar", 64'(ar_ready), 64'd1);
    check_eq("prio1_aw", 64'(aw_ready), 64'd0);
    tick();
    ar_valid = 1'b0;
    r_ready = 1'b1;
    drain_r(4'b1111);
    ar_id = 4'hB;
    ar_valid = 1'b1;
    @(negedge clk);
    check_eq("prio2_aw", 64'(aw_ready), 64'd1);
    check_eq("prio2_ar", 64'(ar_ready), 64'd0);
    tick();
    aw_valid = 1'b0;
    ar_valid = 1'b0;
    begin
      b_exp_t e;
      e.resp = 2'b10; e.id = 4'hA;
      exp_b.push_back(e);
    end
    send_w(64'h0123, 8'hFF, 1'b1);
    send_w(64'h4567, 8'hFF, 1'b0);
    wait_b();

    // Out-of-range accesses on either side of the array, and unsupported burst/size.
    read_burst(LIMIT - 32'h8, 4'hC, 8'd1, 3'd3, 2'b01, 4'b1111, 1'b0);
    read_burst(BASE - 32'h8, 4'hC, 8'd0, 3'd3, 2'b01, 4'b1111, 1'b0);
    read_burst(LIMIT, 4'hC, 8'd0, 3'd3, 2'b01, 4'b1111, 1'b0);
    write_burst(BASE - 32'h8, 4'hD, 8'd0, 3'd3, 2'b01, 64'hBAD0_BAD0_BAD0_BAD0, 8'hFF, 2'b11);
    write_burst(LIMIT, 4'hD, 8'd0, 3'd3, 2'b01, 64'hBAD1_BAD1_BAD1_BAD1, 8'hFF, 2'b11);
    read_burst(LIMIT - 32'h8, 4'hE, 8'd0, 3'd3, 2'b01, 4'b1111, 1'b0);
    read_burst(BASE, 4'hE, 8'd0, 3'd3, 2'b01, 4'b1111, 1'b0);
    read_burst(BASE, 4'h1, 8'd0, 3'd3, 2'b10, 4'b1111, 1'b1);
    read_burst(BASE, 4'h2, 8'd0, 3'd4, 2'b01, 4'b1111, 1'b1);

    // Reset during beat 2 of an 8-beat write: no response, earlier beats retained.
    send_aw(BASE + 32'h100, 4'h3, 8'd7, 3'd3, 2'b01);
    for (int i = 0; i < 2; i++) begin
      send_w(64'hC0DE_0000_0000_0000 + 64'(i), 8'hFF, 1'b0);
      model[widx(BASE + 32'h100 + 32'(i * 8))] = 64'hC0DE_0000_0000_0000 + 64'(i);
    end
    w_data = 64'hC0DE_0000_0000_0002; w_strb = 8'hFF; w_last = 1'b0; w_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_outs", {57'd0, ar_ready, aw_ready, w_ready, b_valid, r_valid, r_last, b_resp != 2'b00}, 64'd0);
    check_eq("midrst_r_data", r_data, 64'd0);
    tick();
    w_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    read_burst(BASE + 32'h100, 4'h4, 8'd1, 3'd3, 2'b01, 4'b1111, 1'b0);
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
